// File: rtl/eh2_lsu_dccm_wr_sched.sv
// eh2_lsu_dccm_wr_sched: one-port DCCM write scheduler with ECC scrubber.
// Picks one write source per cycle: dma, ecc fix, scrub writeback, stbuf.
//
// Ports:
//   clk, rst            core clock, sync active-high reset
//   dma_wr_*            dma write request/addr, grant out
//   ecc_fix_*           single-error fix pulse/addr, overflow pulse out
//   stbuf_*             store-buffer drain request/addr, grant out
//   lsu_rd_busy         pipeline owns the read port this cycle
//   scrub_en            scrubber enable
//   scrub_rd_en/addr    scrub read strobe and row address out
//   scrub_*_err         decode result, one cycle after scrub_rd_en
//   dccm_wren/addr/sel  write port control (sel 0 stb,1 dma,2 fix,3 scrub)
//   scrub_dbl_err_pulse uncorrectable row seen, addr in scrub_err_addr
module eh2_lsu_dccm_wr_sched #(
  parameter int DCCM_BITS      = 16,
  parameter int SCRUB_ROWS     = 4096,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_MAX     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dma_wr_req,
  input  logic [DCCM_BITS-1:0] dma_wr_addr,
  output logic                 dma_wr_gnt,
  input  logic                 ecc_fix_pulse,
  input  logic [DCCM_BITS-1:0] ecc_fix_addr,
  input  logic                 stbuf_req,
  input  logic [DCCM_BITS-1:0] stbuf_addr,
  output logic                 stbuf_gnt,
  input  logic                 lsu_rd_busy,
  input  logic                 scrub_en,
  output logic                 scrub_rd_en,
  output logic [DCCM_BITS-1:0] scrub_rd_addr,
  input  logic                 scrub_single_err,
  input  logic                 scrub_double_err,
  output logic                 dccm_wren,
  output logic [DCCM_BITS-1:0] dccm_wr_addr,
  output logic [1:0]           dccm_wr_sel,
  output logic                 ecc_fix_overflow,
  output logic                 scrub_dbl_err_pulse,
  output logic [DCCM_BITS-1:0] scrub_err_addr
);

  localparam int ROW_W =
    (SCRUB_ROWS > 1) ? $clog2(SCRUB_ROWS) : 1;
  localparam int SC_W =
    (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [15:0] TMR_LAST =
    16'(SCRUB_INTERVAL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(SCRUB_ROWS - 1);
  localparam logic [SC_W-1:0] SC_MAX =
    SC_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ADV  = 3'd4;

  logic [2:0]           state;
  logic [15:0]          timer;
  logic [ROW_W-1:0]     row;
  logic [DCCM_BITS-1:0] row_addr;

  logic                 fix_pend;
  logic [DCCM_BITS-1:0] fix_addr;
  logic [SC_W-1:0]      starve_cnt;

  logic                 dbl_q;
  logic [DCCM_BITS-1:0] err_addr_q;

  logic stb_hi;
  logic wb_req;
  logic dma_g;
  logic fix_g;
  logic scrub_g;
  logic stb_g;
  logic rd_go;

  assign row_addr = DCCM_BITS'({row, 2'b00});

  // A starved store buffer jumps fix and scrub, never dma.
  assign stb_hi  = (starve_cnt == SC_MAX) & stbuf_req;
  assign wb_req  = (state == S_WB);

  // Grants are forced off in the reset cycle.
  assign dma_g   = ~rst & dma_wr_req;
  assign fix_g   = ~rst & ~dma_wr_req & ~stb_hi
                 & fix_pend;
  assign scrub_g = ~rst & ~dma_wr_req & ~stb_hi
                 & ~fix_pend & wb_req;
  assign stb_g   = ~rst & ~dma_wr_req & stbuf_req
                 & (stb_hi | (~fix_pend & ~wb_req));

  assign rd_go   = ~rst & (state == S_RD) & scrub_en
                 & ~lsu_rd_busy & ~dma_wr_req;

  assign dma_wr_gnt  = dma_g;
  assign stbuf_gnt   = stb_g;
  assign dccm_wren   = dma_g | fix_g | scrub_g | stb_g;
  assign scrub_rd_en = rd_go;
  assign scrub_rd_addr = row_addr;

  // A new fix is dropped only if the slot is still occupied.
  assign ecc_fix_overflow = ~rst & ecc_fix_pulse
                          & fix_pend & ~fix_g;

  assign scrub_dbl_err_pulse = dbl_q;
  assign scrub_err_addr      = err_addr_q;

  always_comb begin
    dccm_wr_addr = '0;
    dccm_wr_sel  = 2'd0;
    unique case (1'b1)
      dma_g: begin
        dccm_wr_addr = dma_wr_addr;
        dccm_wr_sel  = 2'd1;
      end
      fix_g: begin
        dccm_wr_addr = fix_addr;
        dccm_wr_sel  = 2'd2;
      end
      scrub_g: begin
        dccm_wr_addr = row_addr;
        dccm_wr_sel  = 2'd3;
      end
      stb_g: begin
        dccm_wr_addr = stbuf_addr;
        dccm_wr_sel  = 2'd0;
      end
      default: begin
        dccm_wr_addr = '0;
        dccm_wr_sel  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fix_pend <= 1'b0;
      fix_addr <= '0;
    end else if (ecc_fix_pulse &
                 (~fix_pend | fix_g)) begin
      fix_pend <= 1'b1;
      fix_addr <= ecc_fix_addr;
    end else if (fix_g) begin
      fix_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | ~stbuf_req | stb_g) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      row        <= '0;
      dbl_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      dbl_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!scrub_en) begin
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            timer <= '0;
            state <= S_RD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RD: begin
          if (!scrub_en) begin
            state <= S_IDLE;
          end else if (rd_go) begin
            state <= S_CHK;
          end
        end
        S_CHK: begin
          if (scrub_double_err) begin
            dbl_q      <= 1'b1;
            err_addr_q <= row_addr;
            state      <= S_ADV;
          end else if (scrub_single_err) begin
            state <= S_WB;
          end else begin
            state <= S_ADV;
          end
        end
        // Writeback finishes even if scrub_en drops.
        S_WB: begin
          if (scrub_g) begin
            state <= S_ADV;
          end
        end
        S_ADV: begin
          row   <= (row == ROW_LAST) ? '0
                 : row + 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eh2_lsu_dccm_wr_sched.sv
// tb_eh2_lsu_dccm_wr_sched: directed checks of arbitration,
// fix latch, starvation promotion, scrubber flow and reset.
module tb_eh2_lsu_dccm_wr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_wr_req;
  logic [15:0] dma_wr_addr;
  logic        dma_wr_gnt;
  logic        ecc_fix_pulse;
  logic [15:0] ecc_fix_addr;
  logic        stbuf_req;
  logic [15:0] stbuf_addr;
  logic        stbuf_gnt;
  logic        lsu_rd_busy;
  logic        scrub_en;
  logic        scrub_rd_en;
  logic [15:0] scrub_rd_addr;
  logic        scrub_single_err;
  logic        scrub_double_err;
  logic        dccm_wren;
  logic [15:0] dccm_wr_addr;
  logic [1:0]  dccm_wr_sel;
  logic        ecc_fix_overflow;
  logic        scrub_dbl_err_pulse;
  logic [15:0] scrub_err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eh2_lsu_dccm_wr_sched #(
    .DCCM_BITS(16),
    .SCRUB_ROWS(8),
    .SCRUB_INTERVAL(4),
    .STARVE_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dma_wr_req(dma_wr_req),
    .dma_wr_addr(dma_wr_addr),
    .dma_wr_gnt(dma_wr_gnt),
    .ecc_fix_pulse(ecc_fix_pulse),
    .ecc_fix_addr(ecc_fix_addr),
    .stbuf_req(stbuf_req),
    .stbuf_addr(stbuf_addr),
    .stbuf_gnt(stbuf_gnt),
    .lsu_rd_busy(lsu_rd_busy),
    .scrub_en(scrub_en),
    .scrub_rd_en(scrub_rd_en),
    .scrub_rd_addr(scrub_rd_addr),
    .scrub_single_err(scrub_single_err),
    .scrub_double_err(scrub_double_err),
    .dccm_wren(dccm_wren),
    .dccm_wr_addr(dccm_wr_addr),
    .dccm_wr_sel(dccm_wr_sel),
    .ecc_fix_overflow(ecc_fix_overflow),
    .scrub_dbl_err_pulse(scrub_dbl_err_pulse),
    .scrub_err_addr(scrub_err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    dma_wr_req       = 1'b0;
    dma_wr_addr      = '0;
    ecc_fix_pulse    = 1'b0;
    ecc_fix_addr     = '0;
    stbuf_req        = 1'b0;
    stbuf_addr       = '0;
    lsu_rd_busy      = 1'b0;
    scrub_en         = 1'b0;
    scrub_single_err = 1'b0;
    scrub_double_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    dma_wr_req = 1'b1;
    stbuf_req  = 1'b1;
    #2;
    checks++;
    if (dma_wr_gnt !== 1'b0 || dccm_wren !== 1'b0
        || stbuf_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_gate: gnt=%b wren=%b stb=%b exp 0",
               dma_wr_gnt, dccm_wren, stbuf_gnt);
    end
    tick();
    tick();
    #1;
    checks++;
    if (scrub_dbl_err_pulse !== 1'b0
        || scrub_err_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_regs: pulse=%b addr=%h exp 0/0000",
               scrub_dbl_err_pulse, scrub_err_addr);
    end
    clr_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if ({dma_wr_gnt, stbuf_gnt, scrub_rd_en, dccm_wren,
         ecc_fix_overflow, scrub_dbl_err_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b exp 000000",
               {dma_wr_gnt, stbuf_gnt, scrub_rd_en, dccm_wren,
                ecc_fix_overflow, scrub_dbl_err_pulse});
    end
    checks++;
    if (dccm_wr_addr !== 16'h0 || dccm_wr_sel !== 2'd0
        || scrub_rd_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_addr: wa=%h sel=%0d ra=%h exp 0",
               dccm_wr_addr, dccm_wr_sel, scrub_rd_addr);
    end
    tick();
  endtask

  task automatic test_dma_vs_stbuf();
    do_reset();
    dma_wr_req  = 1'b1;
    dma_wr_addr = 16'h0200;
    stbuf_req   = 1'b1;
    stbuf_addr  = 16'h0100;
    #1;
    checks++;
    if (dma_wr_gnt !== 1'b1 || stbuf_gnt !== 1'b0
        || dccm_wr_sel !== 2'd1
        || dccm_wr_addr !== 16'h0200) begin
      errors++;
      $display("FAIL dma_win: g=%b s=%b sel=%0d a=%h exp 1 0 1 0200",
               dma_wr_gnt, stbuf_gnt, dccm_wr_sel, dccm_wr_addr);
    end
    tick();
    dma_wr_req = 1'b0;
    #1;
    checks++;
    if (stbuf_gnt !== 1'b1 || dma_wr_gnt !== 1'b0
        || dccm_wr_sel !== 2'd0 || dccm_wren !== 1'b1
        || dccm_wr_addr !== 16'h0100) begin
      errors++;
      $display("FAIL stb_after: s=%b g=%b sel=%0d a=%h exp 1 0 0 0100",
               stbuf_gnt, dma_wr_gnt, dccm_wr_sel, dccm_wr_addr);
    end
    tick();
    stbuf_req = 1'b0;
    #1;
    checks++;
    if (dccm_wren !== 1'b0 || dccm_wr_addr !== 16'h0
        || dccm_wr_sel !== 2'd0) begin
      errors++;
      $display("FAIL no_gnt: wren=%b a=%h sel=%0d exp 0",
               dccm_wren, dccm_wr_addr, dccm_wr_sel);
    end
  endtask

  task automatic test_fix_overflow();
    do_reset();
    ecc_fix_pulse = 1'b1;
    ecc_fix_addr  = 16'h0040;
    #1;
    checks++;
    if (dccm_wren !== 1'b0 || ecc_fix_overflow !== 1'b0) begin
      errors++;
      $display("FAIL fix_c0: wren=%b ovf=%b exp 0 0",
               dccm_wren, ecc_fix_overflow);
    end
    tick();
    ecc_fix_addr = 16'h0080;
    dma_wr_req   = 1'b1;
    dma_wr_addr  = 16'h0300;
    #1;
    checks++;
    if (ecc_fix_overflow !== 1'b1 || dccm_wr_sel !== 2'd1) begin
      errors++;
      $display("FAIL fix_ovf: ovf=%b sel=%0d exp 1 1",
               ecc_fix_overflow, dccm_wr_sel);
    end
    tick();
    ecc_fix_pulse = 1'b0;
    #1;
    checks++;
    if (ecc_fix_overflow !== 1'b0 || dccm_wr_sel !== 2'd1) begin
      errors++;
      $display("FAIL fix_c2: ovf=%b sel=%0d exp 0 1",
               ecc_fix_overflow, dccm_wr_sel);
    end
    tick();
    dma_wr_req = 1'b0;
    #1;
    checks++;
    if (dccm_wren !== 1'b1 || dccm_wr_sel !== 2'd2
        || dccm_wr_addr !== 16'h0040) begin
      errors++;
      $display("FAIL fix_wr: wren=%b sel=%0d a=%h exp 1 2 0040",
               dccm_wren, dccm_wr_sel, dccm_wr_addr);
    end
    tick();
    #1;
    checks++;
    if (dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL fix_once: wren=%b exp 0", dccm_wren);
    end
  endtask

  task automatic test_starve();
    logic [15:0] fa;
    do_reset();
    ecc_fix_pulse = 1'b1;
    ecc_fix_addr  = 16'h0010;
    tick();
    stbuf_req  = 1'b1;
    stbuf_addr = 16'h0020;
    for (int c = 1; c <= 3; c++) begin
      fa = 16'h0010 + 16'(4 * c);
      ecc_fix_addr = fa;
      #1;
      checks++;
      if (dccm_wr_sel !== 2'd2 || stbuf_gnt !== 1'b0
          || ecc_fix_overflow !== 1'b0
          || dccm_wr_addr !== fa - 16'h4) begin
        errors++;
        $display("FAIL starve_fix%0d: sel=%0d s=%b ovf=%b a=%h exp 2 0 0 %h",
                 c, dccm_wr_sel, stbuf_gnt, ecc_fix_overflow,
                 dccm_wr_addr, fa - 16'h4);
      end
      tick();
    end
    ecc_fix_pulse = 1'b0;
    #1;
    checks++;
    if (stbuf_gnt !== 1'b1 || dccm_wr_sel !== 2'd0
        || dccm_wr_addr !== 16'h0020) begin
      errors++;
      $display("FAIL starve_promo: s=%b sel=%0d a=%h exp 1 0 0020",
               stbuf_gnt, dccm_wr_sel, dccm_wr_addr);
    end
    tick();
    stbuf_req = 1'b0;
    #1;
    checks++;
    if (dccm_wr_sel !== 2'd2 || dccm_wr_addr !== 16'h001c
        || dccm_wren !== 1'b1) begin
      errors++;
      $display("FAIL starve_fixlast: sel=%0d a=%h exp 2 001c",
               dccm_wr_sel, dccm_wr_addr);
    end
    tick();
    #1;
    checks++;
    if (dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL starve_idle: wren=%b exp 0", dccm_wren);
    end
  endtask

  task automatic test_scrub_single();
    logic exp_rd;
    logic exp_wr;
    do_reset();
    scrub_en = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      scrub_single_err = (c == 5);
      exp_rd = (c == 4) || (c == 12);
      exp_wr = (c == 6);
      #1;
      checks++;
      if (scrub_rd_en !== exp_rd || dccm_wren !== exp_wr) begin
        errors++;
        $display("FAIL scrub_c%0d: rd=%b wren=%b exp %b %b",
                 c, scrub_rd_en, dccm_wren, exp_rd, exp_wr);
      end
      if (c == 4 || c == 12) begin
        checks++;
        if (scrub_rd_addr !== ((c == 4) ? 16'h0 : 16'h4)) begin
          errors++;
          $display("FAIL scrub_raddr%0d: got %h", c, scrub_rd_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (dccm_wr_sel !== 2'd3 || dccm_wr_addr !== 16'h0) begin
          errors++;
          $display("FAIL scrub_wb: sel=%0d a=%h exp 3 0000",
                   dccm_wr_sel, dccm_wr_addr);
        end
      end
      tick();
    end
    scrub_single_err = 1'b0;
  endtask

  task automatic wait_rd(input logic [15:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (scrub_rd_en === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found || scrub_rd_addr !== exp_addr) begin
      errors++;
      $display("FAIL scrub_rd: found=%b addr=%h exp 1 %h",
               found, scrub_rd_addr, exp_addr);
    end
    tick();
  endtask

  task automatic test_scrub_wrap();
    do_reset();
    scrub_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_rd(16'(4 * k));
    end
    scrub_double_err = 1'b1;
    #1;
    checks++;
    if (dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL dbl_chk: wren=%b exp 0", dccm_wren);
    end
    tick();
    scrub_double_err = 1'b0;
    #1;
    checks++;
    if (scrub_dbl_err_pulse !== 1'b1 || scrub_err_addr !== 16'h001c
        || dccm_wren !== 1'b0) begin
      errors++;
      $display("FAIL dbl_pulse: p=%b a=%h wren=%b exp 1 001c 0",
               scrub_dbl_err_pulse, scrub_err_addr, dccm_wren);
    end
    tick();
    #1;
    checks++;
    if (scrub_dbl_err_pulse !== 1'b0
        || scrub_err_addr !== 16'h001c) begin
      errors++;
      $display("FAIL dbl_once: p=%b a=%h exp 0 001c",
               scrub_dbl_err_pulse, scrub_err_addr);
    end
    wait_rd(16'h0000);
  endtask

  task automatic test_reset_in_wb();
    do_reset();
    scrub_en = 1'b1;
    wait_rd(16'h0000);
    wait_rd(16'h0004);
    scrub_single_err = 1'b1;
    tick();
    scrub_single_err = 1'b0;
    dma_wr_req    = 1'b1;
    dma_wr_addr   = 16'h0300;
    ecc_fix_pulse = 1'b1;
    ecc_fix_addr  = 16'h0044;
    #1;
    checks++;
    if (dccm_wr_sel !== 2'd1 || dma_wr_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wb_blocked: sel=%0d g=%b exp 1 1",
               dccm_wr_sel, dma_wr_gnt);
    end
    tick();
    ecc_fix_pulse = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (dccm_wren !== 1'b0 || dma_wr_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_wb: wren=%b g=%b exp 0 0",
               dccm_wren, dma_wr_gnt);
    end
    tick();
    rst = 1'b0;
    dma_wr_req = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      #1;
      checks++;
      if (dccm_wren !== 1'b0 || scrub_rd_en !== (c == 4)) begin
        errors++;
        $display("FAIL post_rst%0d: wren=%b rd=%b exp 0 %b",
                 c, dccm_wren, scrub_rd_en, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (scrub_rd_addr !== 16'h0) begin
          errors++;
          $display("FAIL post_rst_row: addr=%h exp 0000",
                   scrub_rd_addr);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_dma_vs_stbuf();
    test_fix_overflow();
    test_starve();
    test_scrub_single();
    test_scrub_wrap();
    test_reset_in_wb();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
